// File: rtl/bin_to_bcd_seq_if.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq_if
// Handshake and result bundle between a requester and the sequential
// binary-to-BCD converter.
//   master : drives start / bin_in / dp_en / dp_sel, observes the results
//   slave  : the converter side (bin_to_bcd_seq)
// Signals:
//   start        conversion request, looked at only while the converter is idle
//   bin_in       unsigned value to convert (IN_W bits)
//   dp_en/dp_sel decimal point enable and digit index, captured with bin_in
//   busy         conversion in progress
//   done         one-cycle pulse when val*/dot*/ovf update
//   ovf          captured value exceeded 9999
//   val3..val0   BCD digits, thousands..units
//   dot3..dot0   decimal point flags per digit
// -----------------------------------------------------------------------------
interface bin_to_bcd_seq_if #(
  parameter int IN_W = 14
);
  logic            start;
  logic [IN_W-1:0] bin_in;
  logic            dp_en;
  logic [1:0]      dp_sel;
  logic            busy;
  logic            done;
  logic            ovf;
  logic [3:0]      val3;
  logic [3:0]      val2;
  logic [3:0]      val1;
  logic [3:0]      val0;
  logic            dot3;
  logic            dot2;
  logic            dot1;
  logic            dot0;

  modport master (
    output start, bin_in, dp_en, dp_sel,
    input  busy, done, ovf, val3, val2, val1, val0, dot3, dot2, dot1, dot0
  );

  modport slave (
    input  start, bin_in, dp_en, dp_sel,
    output busy, done, ovf, val3, val2, val1, val0, dot3, dot2, dot1, dot0
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential double-dabble converter: turns an unsigned IN_W-bit value into
// four BCD digits plus decimal point flags for a 4-digit 7-segment driver.
// Results are registered and held between conversions so the display never
// shows intermediate digits.
//
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous reset, active-high (wins over start)
//   bus  bin_to_bcd_seq_if.slave (start, bin_in, dp_en, dp_sel in;
//        busy, done, ovf, val3..val0, dot3..dot0 out)
//
// Parameter IN_W (legal 10..14): input width; a conversion takes IN_W
// iteration cycles, start edge to done is IN_W+1 clocks.
//
// Optional macro BCD_SATURATE_EN: when defined, a captured value above 9999
// loads 9,9,9,9 instead of the value mod 10000. ovf is set in both modes and
// timing and dot outputs are unaffected.
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
  parameter int IN_W = 14
) (
  input  logic                clk,
  input  logic                rst,
  bin_to_bcd_seq_if.slave     bus
);

  localparam int CNT_W = $clog2(IN_W + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CONV     = 2'd1,
    LOAD_OUT = 2'd2
  } state_e;

  state_e          state_q,    state_d;
  logic [IN_W-1:0] shift_q,    shift_d;
  logic [15:0]     bcd_q,      bcd_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic            dp_en_q,    dp_en_d;
  logic [1:0]      dp_sel_q,   dp_sel_d;
  logic            ovf_pend_q, ovf_pend_d;
  logic            busy_q,     busy_d;
  logic            done_q,     done_d;
  logic            ovf_q,      ovf_d;
  logic [15:0]     val_q,      val_d;
  logic [3:0]      dot_q,      dot_d;
  logic [15:0]     adj_bcd;

  // Double-dabble correction for one digit ahead of the doubling shift.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  function automatic logic [15:0] dabble_adjust(input logic [15:0] b);
    return {add3(b[15:12]), add3(b[11:8]), add3(b[7:4]), add3(b[3:0])};
  endfunction

`ifdef BCD_SATURATE_EN
  function automatic logic [15:0] sat_digits(input logic [15:0] acc,
                                             input logic        ov);
    return ov ? 16'h9999 : acc;
  endfunction
`endif

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    dp_en_d    = dp_en_q;
    dp_sel_d   = dp_sel_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    val_d      = val_q;
    dot_d      = dot_q;
    adj_bcd    = dabble_adjust(bcd_q);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d    = bus.bin_in;
          bcd_d      = 16'd0;
          cnt_d      = '0;
          dp_en_d    = bus.dp_en;
          dp_sel_d   = bus.dp_sel;
          ovf_pend_d = ({{(32-IN_W){1'b0}}, bus.bin_in} > 32'd9999);
          busy_d     = 1'b1;
          state_d    = CONV;
        end
      end

      CONV: begin
        // The bit leaving the thousands digit is dropped, so the accumulator
        // ends up holding the value mod 10000.
        bcd_d   = (adj_bcd << 1) | {15'd0, shift_q[IN_W-1]};
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(IN_W - 1)) begin
          state_d = LOAD_OUT;
        end
      end

      LOAD_OUT: begin
`ifdef BCD_SATURATE_EN
        val_d = sat_digits(bcd_q, ovf_pend_q);
`else
        val_d = bcd_q;
`endif
        dot_d   = dp_en_q ? (4'b0001 << dp_sel_q) : 4'b0000;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bcd_q      <= 16'd0;
      cnt_q      <= '0;
      dp_en_q    <= 1'b0;
      dp_sel_q   <= 2'd0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      val_q      <= 16'd0;
      dot_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      dp_en_q    <= dp_en_d;
      dp_sel_q   <= dp_sel_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      val_q      <= val_d;
      dot_q      <= dot_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.val3 = val_q[15:12];
  assign bus.val2 = val_q[11:8];
  assign bus.val1 = val_q[7:4];
  assign bus.val0 = val_q[3:0];
  assign bus.dot3 = dot_q[3];
  assign bus.dot2 = dot_q[2];
  assign bus.dot1 = dot_q[1];
  assign bus.dot0 = dot_q[0];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Self-checking bench for bin_to_bcd_seq (default IN_W = 14): a table of
// directed conversions with hand-computed digits, plus hand-written sequences
// for dropped starts, hold behaviour and reset during a conversion.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

  localparam int IN_W    = 14;
  localparam int LATENCY = IN_W + 1;

  logic clk = 1'b0;
  logic rst;

  bin_to_bcd_seq_if #(.IN_W(IN_W)) bif ();

  bin_to_bcd_seq #(.IN_W(IN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [13:0] bin;
    logic        en;
    logic [1:0]  sel;
    logic [15:0] val;
    logic [3:0]  dot;
    logic        ovf;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] vals();
    return {bif.val3, bif.val2, bif.val1, bif.val0};
  endfunction

  function automatic logic [3:0] dots();
    return {bif.dot3, bif.dot2, bif.dot1, bif.dot0};
  endfunction

  // Issue one start, scramble the inputs during the conversion, and wait
  // (bounded) for done. Checks busy, latency and the done/busy relation.
  task automatic run_conv(input logic [13:0] v, input logic en,
                          input logic [1:0] sel, input string tag);
    int n;
    bif.start  = 1'b1;
    bif.bin_in = v;
    bif.dp_en  = en;
    bif.dp_sel = sel;
    tick();
    bif.start  = 1'b0;
    bif.bin_in = ~v;
    bif.dp_en  = ~en;
    bif.dp_sel = sel + 2'd1;
    chk({tag, " busy after start"}, 32'(bif.busy), 32'd1);
    chk({tag, " done low after start"}, 32'(bif.done), 32'd0);
    n = 0;
    while (!bif.done && n < 40) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(LATENCY));
    chk({tag, " busy low with done"}, 32'(bif.busy), 32'd0);
  endtask

  initial begin
    int dones;
    int first_done;
    logic [15:0] held_val;
    logic [3:0]  held_dot;
    logic        held_ovf;

    // 16383 mod 10000 = 6383; 12345 mod 10000 = 2345; 10000 mod 10000 = 0
`ifdef BCD_SATURATE_EN
    vecs[3] = '{14'd12345, 1'b0, 2'd0, 16'h9999, 4'b0000, 1'b1};
    vecs[6] = '{14'd16383, 1'b1, 2'd0, 16'h9999, 4'b0001, 1'b1};
    vecs[7] = '{14'd10000, 1'b1, 2'd3, 16'h9999, 4'b1000, 1'b1};
`else
    vecs[3] = '{14'd12345, 1'b0, 2'd0, 16'h2345, 4'b0000, 1'b1};
    vecs[6] = '{14'd16383, 1'b1, 2'd0, 16'h6383, 4'b0001, 1'b1};
    vecs[7] = '{14'd10000, 1'b1, 2'd3, 16'h0000, 4'b1000, 1'b1};
`endif
    vecs[0] = '{14'd1234,  1'b0, 2'd0, 16'h1234, 4'b0000, 1'b0};
    vecs[1] = '{14'd0,     1'b0, 2'd0, 16'h0000, 4'b0000, 1'b0};
    vecs[2] = '{14'd9999,  1'b0, 2'd0, 16'h9999, 4'b0000, 1'b0};
    vecs[4] = '{14'd3141,  1'b1, 2'd2, 16'h3141, 4'b0100, 1'b0};
    vecs[5] = '{14'd2718,  1'b0, 2'd2, 16'h2718, 4'b0000, 1'b0};
    vecs[8] = '{14'd9,     1'b0, 2'd1, 16'h0009, 4'b0000, 1'b0};
    vecs[9] = '{14'd1023,  1'b1, 2'd1, 16'h1023, 4'b0010, 1'b0};

    rst        = 1'b1;
    bif.start  = 1'b0;
    bif.bin_in = '0;
    bif.dp_en  = 1'b0;
    bif.dp_sel = 2'd0;
    tick();
    tick();
    rst = 1'b0;

    chk("reset busy", 32'(bif.busy), 32'd0);
    chk("reset done", 32'(bif.done), 32'd0);
    chk("reset ovf",  32'(bif.ovf),  32'd0);
    chk("reset val",  32'(vals()),   32'h0);
    chk("reset dot",  32'(dots()),   32'h0);

    // Back-to-back table: each start is raised in the cycle done is seen.
    for (int i = 0; i < 10; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run_conv(vecs[i].bin, vecs[i].en, vecs[i].sel, tag);
      chk({tag, " val"}, 32'(vals()),   32'(vecs[i].val));
      chk({tag, " dot"}, 32'(dots()),   32'(vecs[i].dot));
      chk({tag, " ovf"}, 32'(bif.ovf),  32'(vecs[i].ovf));
    end

    // Outputs hold with no start while the inputs wander.
    held_val = vals();
    held_dot = dots();
    held_ovf = bif.ovf;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      bif.dp_sel = 2'(c);
      bif.dp_en  = c[0];
      bif.bin_in = 14'(c * 777);
      tick();
      if (bif.done) dones++;
    end
    chk("hold done count", 32'(dones), 32'd0);
    chk("hold val", 32'(vals()), 32'(held_val));
    chk("hold dot", 32'(dots()), 32'(held_dot));
    chk("hold ovf", 32'(bif.ovf), 32'(held_ovf));

    // Starts during a conversion are dropped, not queued.
    bif.start  = 1'b1;
    bif.bin_in = 14'd42;
    bif.dp_en  = 1'b0;
    tick();
    bif.start  = 1'b0;
    dones      = 0;
    first_done = -1;
    for (int n = 1; n <= 30; n++) begin
      bif.start  = (n == 3 || n == 10);
      bif.bin_in = 14'd777;
      tick();
      if (bif.done) begin
        dones++;
        if (first_done < 0) first_done = n;
      end
    end
    bif.start = 1'b0;
    chk("drop done count", 32'(dones), 32'd1);
    chk("drop latency", 32'(first_done), 32'(LATENCY));
    chk("drop val", 32'(vals()), 32'h0042);

    // Set dots, then reset in the middle of a conversion of 5678.
    run_conv(14'd3141, 1'b1, 2'd2, "pre-reset");
    chk("pre-reset dot", 32'(dots()), 32'b0100);
    bif.start  = 1'b1;
    bif.bin_in = 14'd5678;
    bif.dp_en  = 1'b1;
    bif.dp_sel = 2'd0;
    tick();
    bif.start = 1'b0;
    for (int n = 0; n < 6; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst busy", 32'(bif.busy), 32'd0);
    chk("midrst done", 32'(bif.done), 32'd0);
    chk("midrst val",  32'(vals()),   32'h0);
    chk("midrst dot",  32'(dots()),   32'h0);
    chk("midrst ovf",  32'(bif.ovf),  32'd0);
    dones = 0;
    for (int n = 0; n < 25; n++) begin
      tick();
      if (bif.done) dones++;
    end
    chk("midrst no done", 32'(dones), 32'd0);
    run_conv(14'd5678, 1'b0, 2'd0, "post-reset");
    chk("post-reset val", 32'(vals()), 32'h5678);

    // rst and start together: reset wins, nothing starts.
    rst        = 1'b1;
    bif.start  = 1'b1;
    bif.bin_in = 14'd100;
    tick();
    rst       = 1'b0;
    bif.start = 1'b0;
    chk("rst+start busy", 32'(bif.busy), 32'd0);
    chk("rst+start val", 32'(vals()), 32'h0);
    dones = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (bif.done) dones++;
    end
    chk("rst+start no done", 32'(dones), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
